// File: rtl/stream_config_ctrl.sv
// Register-mapped sequencer: stages config-bus writes and issues each committed value
// exactly once on its ready/valid channel (in_select, out_select, data_type, buffer).
module stream_config_ctrl #(
  parameter int unsigned NUM_SELECT = 4,
  parameter int unsigned TYPE_BITS = 4,
  parameter int unsigned BUF_BITS = 96,
  parameter int unsigned AXI_ADDR_BITS = 32,
  parameter logic [AXI_ADDR_BITS-1:0] BASE_ADDR = 32'h0000_0040,
  parameter int unsigned CNT_BITS = 16,
  localparam int unsigned SEL_BITS = (NUM_SELECT > 1) ? $clog2(NUM_SELECT) : 1,
  localparam int unsigned AXIL_DATA_BITS = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_BITS-1:0]  cfg_addr,
  input  logic [AXIL_DATA_BITS-1:0] cfg_data,
  input  logic                      cfg_valid,
  output logic [SEL_BITS-1:0]       in_sel_data,
  output logic                      in_sel_valid,
  input  logic                      in_sel_ready,
  output logic [SEL_BITS-1:0]       out_sel_data,
  output logic                      out_sel_valid,
  input  logic                      out_sel_ready,
  output logic [TYPE_BITS-1:0]      type_data,
  output logic                      type_valid,
  input  logic                      type_ready,
  output logic [BUF_BITS-1:0]       buf_data,
  output logic                      buf_valid,
  input  logic                      buf_ready,
  output logic                      busy,
  output logic [CNT_BITS-1:0]       overflow_cnt
);

  logic [SEL_BITS-1:0]  in_stg_q, in_stg_d, out_stg_q, out_stg_d;
  logic [TYPE_BITS-1:0] type_stg_q, type_stg_d;
  logic [BUF_BITS-1:0]  buf_stg_q, buf_stg_d;
  logic [SEL_BITS-1:0]  in_sel_q, in_sel_d, out_sel_q, out_sel_d;
  logic [TYPE_BITS-1:0] type_q, type_d;
  logic [BUF_BITS-1:0]  buf_q, buf_d;
  logic [3:0]           valid_q, valid_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  logic                 hit_s;
  logic [2:0]           word_s;
  logic [3:0]           commit_s, load_s, ready_s;
  logic [2:0]           drop_s;
  logic [CNT_BITS:0]    sum_s;
  logic                 unused_addr_bits;

  assign ready_s = {buf_ready, type_ready, out_sel_ready, in_sel_ready};
  assign unused_addr_bits = ^cfg_addr[2:0];

  // Decode, staging updates, per-channel commit/handshake and overflow accounting
  always_comb begin
    in_stg_d   = in_stg_q;
    out_stg_d  = out_stg_q;
    type_stg_d = type_stg_q;
    buf_stg_d  = buf_stg_q;
    valid_d    = valid_q;
    load_s     = 4'b0000;
    drop_s     = 3'd0;
    hit_s      = cfg_valid && (cfg_addr[AXI_ADDR_BITS-1:6] == BASE_ADDR[AXI_ADDR_BITS-1:6]);
    // Word 7 doubles as the "nothing to do" code for misses
    word_s     = hit_s ? cfg_addr[5:3] : 3'd7;
    commit_s   = (word_s == 3'd5) ? cfg_data[3:0] : 4'b0000;
    case (word_s)
      3'd0:    in_stg_d = cfg_data[SEL_BITS-1:0];
      3'd1:    out_stg_d = cfg_data[SEL_BITS-1:0];
      3'd2:    type_stg_d = cfg_data[TYPE_BITS-1:0];
      3'd3:    buf_stg_d[63:0] = cfg_data;
      3'd4:    buf_stg_d[BUF_BITS-1:64] = cfg_data[BUF_BITS-65:0];
      default: buf_stg_d = buf_stg_q;
    endcase
    for (int c = 0; c < 4; c++) begin
      if (commit_s[c]) begin
        if (valid_q[c] && !ready_s[c]) begin
          drop_s = drop_s + 3'd1;
        end else begin
          load_s[c]  = 1'b1;
          valid_d[c] = 1'b1;
        end
      end else if (ready_s[c]) begin
        valid_d[c] = 1'b0;
      end else begin
        valid_d[c] = valid_q[c];
      end
    end
    in_sel_d  = load_s[0] ? in_stg_q : in_sel_q;
    out_sel_d = load_s[1] ? out_stg_q : out_sel_q;
    type_d    = load_s[2] ? type_stg_q : type_q;
    buf_d     = load_s[3] ? buf_stg_q : buf_q;
    sum_s     = {1'b0, cnt_q} + {{(CNT_BITS-2){1'b0}}, drop_s};
    cnt_d     = sum_s[CNT_BITS] ? {CNT_BITS{1'b1}} : sum_s[CNT_BITS-1:0];
    busy_d    = |valid_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      in_stg_q   <= '0;
      out_stg_q  <= '0;
      type_stg_q <= '0;
      buf_stg_q  <= '0;
      in_sel_q   <= '0;
      out_sel_q  <= '0;
      type_q     <= '0;
      buf_q      <= '0;
      valid_q    <= 4'b0000;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      in_stg_q   <= in_stg_d;
      out_stg_q  <= out_stg_d;
      type_stg_q <= type_stg_d;
      buf_stg_q  <= buf_stg_d;
      in_sel_q   <= in_sel_d;
      out_sel_q  <= out_sel_d;
      type_q     <= type_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign in_sel_data   = in_sel_q;
  assign out_sel_data  = out_sel_q;
  assign type_data     = type_q;
  assign buf_data      = buf_q;
  assign in_sel_valid  = valid_q[0];
  assign out_sel_valid = valid_q[1];
  assign type_valid    = valid_q[2];
  assign buf_valid     = valid_q[3];
  assign busy          = busy_q;
  assign overflow_cnt  = cnt_q;

endmodule

// File: doc/stream_config_ctrl.md
Name: stream_config_ctrl

Overview:
- Register-mapped sequencer between the AXI-Lite config write bus (flattened config_i: addr/data/valid) and the per-stream configuration channels.
- Channels driven: in_select, out_select and data_type of one stream, plus the buffer channel of one memory port. All channels are ready/valid.
- Software writes staging registers, then writes a COMMIT mask. The block issues each committed value exactly once, honouring backpressure.
- Instantiated once per stream/memory pair, next to the config bus decoder.

Parameters:
- NUM_SELECT, 4, number of selectable sources/sinks. SEL_BITS = $clog2(NUM_SELECT).
- TYPE_BITS, 4, width of type_t.
- BUF_BITS, 96, width of buffer_t. Legal range 65..128.
- BASE_ADDR, 'h40, byte base address of this block's 6-register window. Must be 64-byte aligned.
- CNT_BITS, 16, width of the overflow counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_addr  in  AXI_ADDR_BITS  config write byte address.
- cfg_data  in  AXIL_DATA_BITS (64)  config write data.
- cfg_valid  in  1  config write strobe. No backpressure.
- in_sel_data  out  SEL_BITS  in_select payload.
- in_sel_valid  out  1.
- in_sel_ready  in  1.
- out_sel_data  out  SEL_BITS  out_select payload.
- out_sel_valid  out  1.
- out_sel_ready  in  1.
- type_data  out  TYPE_BITS  data_type payload.
- type_valid  out  1.
- type_ready  in  1.
- buf_data  out  BUF_BITS  buffer payload.
- buf_valid  out  1.
- buf_ready  in  1.
- busy  out  1  OR of all four *_valid.
- overflow_cnt  out  CNT_BITS  saturating count of dropped commits.

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high. All state updates on the rising edge.
- Reset values: all *_valid = 0, all *_data = 0, staging registers = 0, overflow_cnt = 0, busy = 0. Reset mid-transfer drops pending values immediately with no handshake completion.
- Decode:
  - Hit when cfg_valid is high and cfg_addr[AXI_ADDR_BITS-1:6] equals BASE_ADDR[AXI_ADDR_BITS-1:6].
  - Word index is cfg_addr[5:3]; cfg_addr[2:0] is ignored.
  - Word 0 (0x00) IN_SEL: stage cfg_data[SEL_BITS-1:0].
  - Word 1 (0x08) OUT_SEL: stage cfg_data[SEL_BITS-1:0].
  - Word 2 (0x10) TYPE: stage cfg_data[TYPE_BITS-1:0].
  - Word 3 (0x18) BUF_LO: stage buf[63:0].
  - Word 4 (0x20) BUF_HI: stage buf[BUF_BITS-1:64] from the low bits of cfg_data.
  - Word 5 (0x28) COMMIT: mask bit0 in_sel, bit1 out_sel, bit2 type, bit3 buf. Higher bits ignored.
  - Words 6–7 and misses are ignored with no side effects. Out-of-range high data bits are silently truncated.
- Staging writes take effect the next cycle and never alter an in-flight output.
- Per-channel commit, for each mask bit set:
  - Channel idle (valid=0) or accepted this cycle (valid&ready): next cycle data <= staging, valid <= 1. Staging value is sampled in the commit cycle.
  - Channel valid=1 and ready=0: commit for that channel is dropped and overflow_cnt += 1. Each dropped channel counts separately, so up to +4 per write. Saturates at 2^CNT_BITS-1.
- Handshake:
  - Transfer occurs when valid & ready.
  - Without a same-cycle commit, valid drops the next cycle.
  - While valid=1 and ready=0, data and valid are held stable.
  - Valid never depends combinationally on ready.
- Latency: COMMIT write in cycle N gives valid=1 in cycle N+1. A staging write at N followed by COMMIT at N+1 issues the new value at N+2.
- Channels are independent; no ordering is imposed between them.
- busy is registered-consistent: it is the OR of the current valid outputs.

Test Plan:
- Reset, then write 0x40←2, 0x48←1, 0x50←3, 0x68←0x7 with all readies held at 1 → cycle after COMMIT: in_sel_data=2, out_sel_data=1, type_data=3, each valid for exactly 1 cycle; buf_valid stays 0; overflow_cnt=0.
- Write BUF_LO←0xDEADBEEF_00001000 and BUF_HI←0x40, COMMIT←0x8, buf_ready=0 for 5 cycles then 1 → buf_data=0x40_DEADBEEF_00001000 held stable 6 cycles, one transfer, then valid=0.
- While buf is stalled, write BUF_LO←0x1 then COMMIT←0x8 → overflow_cnt=1; buf_data unchanged; after acceptance, buf_valid=0.
- With type_valid=1 and type_ready=1 in the same cycle as COMMIT←0x4 with staged type 5 → valid stays 1, next data=5, overflow_cnt unchanged.
- Write to 0x80 (miss) and to 0x70 (word 6) → no staging change, no valid activity; write 0x40←0x1F with NUM_SELECT=4 → staged in_sel=3.
- Assert rst while out_sel_valid=1 and out_sel_ready=0 → next cycle all valids=0, data=0, overflow_cnt=0, busy=0.
